// File: rtl/adpll_lock_controller.sv
// ADPLL gear-shift and lock-detect sequencer: counts filter correction events per window of
// reference edges, steps ACQUIRE -> TRACK -> LOCKED and falls back when slips get large.
module adpll_lock_controller #(
    parameter int unsigned WIN_EDGES     = 16,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned LOCK_THRESH   = 2,
    parameter int unsigned UNLOCK_THRESH = 8,
    parameter int unsigned LOCK_WINDOWS  = 4,
    parameter int unsigned KW            = 4,
    parameter logic [KW-1:0] K_ACQ       = KW'(3),
    parameter logic [KW-1:0] K_TRK       = KW'(6)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             ref_signal,
    input  logic             carry,
    input  logic             borrow,
    output logic [KW-1:0]    k_sel,
    output logic             filter_clear,
    output logic             locked,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] slip_cnt,
    output logic             window_done
);

    localparam int unsigned EW = (WIN_EDGES > 1) ? $clog2(WIN_EDGES) : 1;
    localparam int unsigned GW = $clog2(LOCK_WINDOWS + 1);
    localparam logic [CNT_W-1:0] EVT_MAX  = '1;
    localparam logic [CNT_W-1:0] LOCK_T   = CNT_W'(LOCK_THRESH);
    localparam logic [CNT_W-1:0] UNLOCK_T = CNT_W'(UNLOCK_THRESH);
    localparam logic [EW-1:0]    LAST_EDGE = EW'(WIN_EDGES - 1);
    localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_WINDOWS - 1);
    localparam logic [GW-1:0]    GOOD_MAX  = GW'(LOCK_WINDOWS);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StTrack   = 2'd2,
        StLocked  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             ref_d;
    logic [EW-1:0]    edge_cnt;
    logic [CNT_W-1:0] evt_cnt;
    logic [GW-1:0]    good_cnt;

    logic             ref_rise, running, win_close, good_win, good_full, unlock, state_chg;
    logic [CNT_W:0]   evt_sum;
    logic [CNT_W-1:0] evt_total;

    assign ref_rise  = ref_signal & ~ref_d;
    assign running   = (state_q != StIdle);
    assign evt_sum   = {1'b0, evt_cnt} + {{CNT_W{1'b0}}, carry} + {{CNT_W{1'b0}}, borrow};
    // Saturate so a runaway loop never wraps back into the "good" range.
    assign evt_total = evt_sum[CNT_W] ? EVT_MAX : evt_sum[CNT_W-1:0];
    assign win_close = running && ref_rise && (edge_cnt == LAST_EDGE);
    assign good_win  = (evt_total <= LOCK_T);
    assign good_full = good_win && (good_cnt >= GOOD_LAST);
    assign unlock    = (evt_total > UNLOCK_T);
    assign state_chg = (state_d != state_q);
    assign state     = state_q;

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    state_d = StAcquire;
                StAcquire: if (win_close && good_full) state_d = StTrack;
                StTrack: begin
                    if (win_close && unlock)         state_d = StAcquire;
                    else if (win_close && good_full) state_d = StLocked;
                end
                StLocked:  if (win_close && unlock) state_d = StAcquire;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            ref_d        <= 1'b0;
            edge_cnt     <= '0;
            evt_cnt      <= '0;
            good_cnt     <= '0;
            k_sel        <= K_ACQ;
            filter_clear <= 1'b0;
            locked       <= 1'b0;
            slip_cnt     <= '0;
            window_done  <= 1'b0;
        end else begin
            ref_d        <= ref_signal;
            state_q      <= state_d;
            k_sel        <= (state_d == StTrack || state_d == StLocked) ? K_TRK : K_ACQ;
            locked       <= (state_d == StLocked);
            filter_clear <= state_chg && (state_d == StAcquire || state_d == StTrack);
            window_done  <= win_close;
            if (win_close) slip_cnt <= evt_total;

            // Any state change restarts measurement so the next window is full-length.
            if (state_chg || win_close || !running) begin
                edge_cnt <= '0;
                evt_cnt  <= '0;
            end else begin
                evt_cnt <= evt_total;
                if (ref_rise) edge_cnt <= edge_cnt + EW'(1);
            end

            if (state_chg || !running) begin
                good_cnt <= '0;
            end else if (win_close) begin
                if (!good_win)                good_cnt <= '0;
                else if (good_cnt != GOOD_MAX) good_cnt <= good_cnt + GW'(1);
            end
        end
    end

endmodule

// File: doc/adpll_lock_controller.md
Name: adpll_lock_controller

Overview:
Gear-shift and lock-detect sequencer for the ADPLL loop filter. It monitors the FILTER carry/borrow correction pulses over windows of reference edges. It selects the K-counter modulus exponent: wide for acquisition, narrow for tracking. It issues a single-cycle clear to the filter on gear changes and reports lock to the rest of the design.

Parameters:
WIN_EDGES, 16, reference rising edges per measurement window
CNT_W, 8, width of the per-window correction-event counter (saturating)
LOCK_THRESH, 2, max events in a window for it to count as "good"
UNLOCK_THRESH, 8, events in a window above which TRACK/LOCKED falls back to ACQUIRE
LOCK_WINDOWS, 4, consecutive good windows required to advance state
KW, 4, width of k_sel
K_ACQ, 3, k_sel value in IDLE/ACQUIRE
K_TRK, 6, k_sel value in TRACK/LOCKED

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
enable  input  1  loop enable; 0 forces IDLE
ref_signal  input  1  reference clock, synchronous to clk
carry  input  1  filter carry pulse, one event per clk cycle high
borrow  input  1  filter borrow pulse, one event per clk cycle high
k_sel  output  KW  filter modulus exponent
filter_clear  output  1  one-cycle clear pulse to the loop filter
locked  output  1  high only in LOCKED
state  output  2  0=IDLE 1=ACQUIRE 2=TRACK 3=LOCKED
slip_cnt  output  CNT_W  event count of the last completed window
window_done  output  1  one-cycle pulse when slip_cnt updates

Behaviour:
- Reset (reset=0 at clk edge): state=IDLE, k_sel=K_ACQ, filter_clear=0, locked=0, slip_cnt=0, window_done=0. Clears the edge counter, event counter, good-window counter and ref_d. Reset dominates all other inputs.
- Edge detect: ref_d is a register of ref_signal; ref_rise = ref_signal & ~ref_d.
- Event counter: each cycle adds carry+borrow (0, 1 or 2). Both inputs high in one cycle adds 2. The counter saturates at 2^CNT_W-1 and never wraps.
- Window close: occurs on the cycle where ref_rise=1 and the edge counter = WIN_EDGES-1.
  - Events in the closing cycle belong to the closing window.
  - Next edge: slip_cnt <= total, window_done=1 for one cycle, edge and event counters restart at 0.
- Counters only run in ACQUIRE/TRACK/LOCKED. They are held at 0 in IDLE. They clear on every state change, so the first window after any transition is full-length.
- Good window: slip total <= LOCK_THRESH. A good window increments good_cnt; any other window clears it.
- FSM transitions, evaluated at window close unless noted:
  - IDLE -> ACQUIRE when enable=1 (not window-gated).
  - ACQUIRE -> TRACK when the LOCK_WINDOWS-th consecutive good window closes.
  - TRACK -> LOCKED when the LOCK_WINDOWS-th consecutive good window closes.
  - TRACK or LOCKED -> ACQUIRE when slip total > UNLOCK_THRESH. Fallback has priority over advance.
  - Any state -> IDLE on the next edge when enable=0. Takes priority over window transitions in the same cycle.
  - good_cnt clears on every transition.
- filter_clear: high for exactly one cycle, the first cycle the new state is visible, on entry to ACQUIRE (from IDLE or fallback) and to TRACK. There is no pulse on entry to LOCKED or IDLE.
- k_sel: K_ACQ in IDLE/ACQUIRE, K_TRK in TRACK/LOCKED. Registered and changes on the same edge as state.
- locked = (state==LOCKED), registered.
- All outputs registered; there are no combinational input-to-output paths.

Test Plan:
1. Reset: hold reset=0 4 cycles with enable=1, carry=1 -> state=0, k_sel=3, locked=0, slip_cnt=0, filter_clear=0 throughout.
2. Clean lock: defaults, ref period 60 clks, no carry/borrow, enable=1.
   - filter_clear pulses once on entry to state=1.
   - After 64 ref edges: state=2, k_sel=6, one filter_clear pulse.
   - After 64 more edges: state=3, locked=1, no clear pulse.
   - window_done pulses every 16 edges with slip_cnt=0.
3. Unlock: in LOCKED, inject 9 carry pulses within one window -> slip_cnt=9, state=1, locked=0, k_sel=3, one filter_clear pulse. A window with exactly 8 events keeps LOCKED.
4. Good-run reset: in ACQUIRE, 3 windows with 2 events each then one window with 3 events -> state stays 1, and 4 further good windows are needed to reach state 2.
5. Arithmetic:
   - carry and borrow both high for 2 cycles in a window -> slip_cnt=4.
   - 300 carry cycles in a window (long ref period) -> slip_cnt=255 (no wrap).
6. Abort: drop enable in LOCKED -> state=0, locked=0, k_sel=3 next cycle, no filter_clear. Assert reset=0 mid-window in TRACK -> full reset values. Re-enable -> full 16-edge first window.
